// File: rtl/i2c_reg_bank.sv
// Register bank behind the board CPLD I2C slave: ID, scratch, locked controls,
// pulse outputs and synchronized status with interrupt. Option: REG_BANK_ERR_CNT_EN.
module i2c_reg_bank #(
    parameter logic [7:0]  BOARD_ID     = 8'h5A,
    parameter logic [7:0]  FW_VER       = 8'h10,
    parameter logic [7:0]  CTRL0_RST    = 8'h00,
    parameter logic [7:0]  CTRL1_RST    = 8'h00,
    parameter logic [15:0] PULSE_WIDTH  = 16'd16,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd10000000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wrdata,
    input  logic       wrdata_en,
    output logic [7:0] rdata,
    output logic [7:0] ctrl0,
    output logic [7:0] ctrl1,
    output logic [7:0] pulse_out,
    input  logic [7:0] status_in,
    output logic       irq_n,
    output logic       unlocked
);

    localparam logic [1:0] LOCKED   = 2'd0;
    localparam logic [1:0] KEY1     = 2'd1;
    localparam logic [1:0] UNLOCKED = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [23:0] idle_cnt;
    logic        timeout;
    logic [7:0]  scratch, sticky, mask;
    logic [15:0] pulse_cnt;
    logic [7:0]  sync1, sync2, sync3;
    logic [7:0]  rise, clr;
    logic        addr_mapped, prot_hit;
    logic        wr_key, wr_scr, wr_c0, wr_c1, wr_pls, wr_stk, wr_msk;

    assign wr_key = wrdata_en && (reg_addr == 8'h03);
    assign wr_scr = wrdata_en && (reg_addr == 8'h02);
    assign wr_c0  = wrdata_en && (reg_addr == 8'h04);
    assign wr_c1  = wrdata_en && (reg_addr == 8'h05);
    assign wr_pls = wrdata_en && (reg_addr == 8'h06);
    assign wr_stk = wrdata_en && (reg_addr == 8'h09);
    assign wr_msk = wrdata_en && (reg_addr == 8'h0A);

    assign prot_hit = wr_c0 || wr_c1 || wr_pls;
    assign timeout  = (idle_cnt == LOCK_TIMEOUT);
    assign unlocked = (state == UNLOCKED);
    assign rise     = sync2 & ~sync3;
    assign clr      = wr_stk ? wrdata : 8'h00;

    // Key sequence: A5 then 5A to KEY; any stray write or idle timeout relocks
    always_comb begin
        state_nxt = state;
        case (state)
            LOCKED: begin
                if (wr_key && (wrdata == 8'hA5)) state_nxt = KEY1;
            end
            KEY1: begin
                if (wrdata_en)
                    state_nxt = (wr_key && (wrdata == 8'h5A)) ? UNLOCKED : LOCKED;
                else if (timeout)
                    state_nxt = LOCKED;
            end
            UNLOCKED: begin
                if (wr_key || timeout) state_nxt = LOCKED;
            end
            default: state_nxt = LOCKED;
        endcase
    end

    // Lock state and idle counter; counter saturates at the timeout value
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOCKED;
            idle_cnt <= 24'd0;
        end else begin
            state <= state_nxt;
            if (wrdata_en)
                idle_cnt <= 24'd0;
            else if (!timeout)
                idle_cnt <= idle_cnt + 24'd1;
        end
    end

    // Plain and write-protected configuration registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch <= 8'h00;
            mask    <= 8'h00;
            ctrl0   <= CTRL0_RST;
            ctrl1   <= CTRL1_RST;
        end else begin
            if (wr_scr) scratch <= wrdata;
            if (wr_msk) mask <= wrdata;
            if (wr_c0 && unlocked) ctrl0 <= wrdata;
            if (wr_c1 && unlocked) ctrl1 <= wrdata;
        end
    end

    // Pulse outputs stay high PULSE_WIDTH cycles from the last write
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_out <= 8'h00;
            pulse_cnt <= 16'd0;
        end else if (wr_pls && unlocked) begin
            pulse_out <= wrdata;
            pulse_cnt <= PULSE_WIDTH;
        end else if (pulse_cnt != 16'd0) begin
            if (pulse_cnt == 16'd1) pulse_out <= 8'h00;
            pulse_cnt <= pulse_cnt - 16'd1;
        end
    end

    // Status synchronizer, edge detect, sticky (set beats clear) and irq
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 8'h00;
            sync2  <= 8'h00;
            sync3  <= 8'h00;
            sticky <= 8'h00;
            irq_n  <= 1'b1;
        end else begin
            sync1  <= status_in;
            sync2  <= sync1;
            sync3  <= sync2;
            sticky <= (sticky & ~clr) | rise;
            irq_n  <= ~|(sticky & mask);
        end
    end

    // Addresses that count as decoded for write purposes
    always_comb begin
        addr_mapped = 1'b0;
        case (reg_addr)
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h08, 8'h09, 8'h0A: addr_mapped = 1'b1;
`ifdef REG_BANK_ERR_CNT_EN
            8'h0B: addr_mapped = 1'b1;
`endif
            default: addr_mapped = 1'b0;
        endcase
    end

`ifdef REG_BANK_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic       err_evt, wr_err;

    assign wr_err  = wrdata_en && (reg_addr == 8'h0B);
    assign err_evt = (prot_hit && !unlocked) || (wrdata_en && !addr_mapped);

    // Saturating error counter; a write clears it even alongside an error
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'h00;
        else if (wr_err)
            err_cnt <= 8'h00;
        else if (err_evt && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'h01;
    end
`else
    logic unused_dec;
    assign unused_dec = prot_hit ^ addr_mapped;
`endif

    // Zero-latency read mux
    always_comb begin
        rdata = 8'h00;
        case (reg_addr)
            8'h00: rdata = BOARD_ID;
            8'h01: rdata = FW_VER;
            8'h02: rdata = scratch;
            8'h03: rdata = {7'b0, unlocked};
            8'h04: rdata = ctrl0;
            8'h05: rdata = ctrl1;
            8'h08: rdata = sync2;
            8'h09: rdata = sticky;
            8'h0A: rdata = mask;
`ifdef REG_BANK_ERR_CNT_EN
            8'h0B: rdata = err_cnt;
`endif
            default: rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: lock FSM, pulses, status/irq, error counter.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_i2c_reg_bank;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [7:0] reg_addr;
    logic [7:0] wrdata;
    logic       wrdata_en;
    logic [7:0] rdata;
    logic [7:0] ctrl0;
    logic [7:0] ctrl1;
    logic [7:0] pulse_out;
    logic [7:0] status_in;
    logic       irq_n;
    logic       unlocked;

    int checks = 0;
    int errors = 0;
    int n;

    i2c_reg_bank #(
        .PULSE_WIDTH (16'd16),
        .LOCK_TIMEOUT(24'd100)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .reg_addr (reg_addr),
        .wrdata   (wrdata),
        .wrdata_en(wrdata_en),
        .rdata    (rdata),
        .ctrl0    (ctrl0),
        .ctrl1    (ctrl1),
        .pulse_out(pulse_out),
        .status_in(status_in),
        .irq_n    (irq_n),
        .unlocked (unlocked)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        reg_addr  = a;
        wrdata    = d;
        wrdata_en = 1'b1;
        @(negedge sys_clk);
        wrdata_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input string tag);
        reg_addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic unlock();
        wr(8'h03, 8'hA5);
        wr(8'h03, 8'h5A);
    endtask

    initial begin
        rst_n     = 1'b0;
        reg_addr  = 8'h00;
        wrdata    = 8'h00;
        wrdata_en = 1'b0;
        status_in = 8'h00;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);

        rd(8'h00, 8'h5A, "id");
        rd(8'h01, 8'h10, "ver");
        rd(8'h04, 8'h00, "ctrl0_rst");
        check("irq_rst", irq_n, 1'b1);
        check("unl_rst", unlocked, 1'b0);
        check("pulse_rst", pulse_out, 8'h00);

        wr(8'h04, 8'h3C);
        check("ctrl0_locked", ctrl0, 8'h00);
        unlock();
        check("unl_after_key", unlocked, 1'b1);
        rd(8'h03, 8'h01, "key_rd_unl");
        wr(8'h04, 8'h3C);
        check("ctrl0_wr", ctrl0, 8'h3C);
        rd(8'h04, 8'h3C, "ctrl0_rd");
        wr(8'h05, 8'h77);
        check("ctrl1_wr", ctrl1, 8'h77);
        wr(8'h03, 8'h00);
        check("relock", unlocked, 1'b0);

        wr(8'h03, 8'hA5);
        wr(8'h02, 8'h11);
        wr(8'h03, 8'h5A);
        check("key_broken", unlocked, 1'b0);
        rd(8'h02, 8'h11, "scratch");
        rd(8'h07, 8'h00, "unmapped_rd");

        unlock();
        repeat (90) @(negedge sys_clk);
        check("idle_90", unlocked, 1'b1);
        repeat (20) @(negedge sys_clk);
        check("idle_110", unlocked, 1'b0);

        unlock();
        wr(8'h06, 8'h81);
        rd(8'h06, 8'h00, "pulse_rd");
        n = 0;
        while (pulse_out === 8'h81 && n < 100) begin
            n++;
            @(negedge sys_clk);
        end
        check("pulse_len", n, 16);
        check("pulse_end", pulse_out, 8'h00);

        wr(8'h06, 8'h81);
        repeat (4) @(negedge sys_clk);
        wr(8'h06, 8'h02);
        check("pulse_repl", pulse_out, 8'h02);
        n = 0;
        while (pulse_out === 8'h02 && n < 100) begin
            n++;
            @(negedge sys_clk);
        end
        check("pulse_relen", n, 16);
        check("pulse_reend", pulse_out, 8'h00);

        status_in = 8'h08;
        repeat (3) @(negedge sys_clk);
        rd(8'h09, 8'h08, "sticky_set");
        rd(8'h08, 8'h08, "live");
        wr(8'h0A, 8'h08);
        @(negedge sys_clk);
        check("irq_on", irq_n, 1'b0);

        status_in = 8'h00;
        repeat (4) @(negedge sys_clk);
        status_in = 8'h08;
        @(negedge sys_clk);
        @(negedge sys_clk);
        wr(8'h09, 8'h08);
        rd(8'h09, 8'h08, "set_wins");
        @(negedge sys_clk);
        check("irq_hold", irq_n, 1'b0);

        wr(8'h09, 8'h08);
        rd(8'h09, 8'h00, "sticky_clr");
        check("irq_lag", irq_n, 1'b0);
        @(negedge sys_clk);
        check("irq_off", irq_n, 1'b1);

        wr(8'h03, 8'h00);
        check("locked_err", unlocked, 1'b0);
`ifdef REG_BANK_ERR_CNT_EN
        wr(8'h0B, 8'h00);
        rd(8'h0B, 8'h00, "err_clr0");
        repeat (3) wr(8'h07, 8'h01);
        rd(8'h0B, 8'h03, "err_3");
        for (int i = 0; i < 300; i++) wr(8'h04, 8'h55);
        rd(8'h0B, 8'hFF, "err_sat");
        check("ctrl0_kept", ctrl0, 8'h3C);
        wr(8'h0B, 8'h12);
        rd(8'h0B, 8'h00, "err_clr");
`else
        wr(8'h0B, 8'h12);
        rd(8'h0B, 8'h00, "no_err_reg");
`endif

        unlock();
        wr(8'h06, 8'hFF);
        check("pre_rst_pulse", pulse_out, 8'hFF);
        rst_n = 1'b0;
        #1;
        check("rst_pulse", pulse_out, 8'h00);
        check("rst_unl", unlocked, 1'b0);
        check("rst_ctrl0", ctrl0, 8'h00);
        check("rst_ctrl1", ctrl1, 8'h00);
        check("rst_irq", irq_n, 1'b1);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        rd(8'h02, 8'h00, "rst_scratch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_reg_bank.md
Name: i2c_reg_bank

Overview:
- Register file sitting directly downstream of the board CPLD's I2C slave interface.
- Consumes reg_addr/wrdata/wrdata_en and returns rdata combinationally.
- Holds ID/version, scratch, write-protected control registers, a self-clearing pulse register, and synchronized live/sticky status with a maskable active-low interrupt.

Parameters:
BOARD_ID, 8'h5A, value returned at 0x00
FW_VER, 8'h10, value returned at 0x01
CTRL0_RST, 8'h00, reset value of CTRL0
CTRL1_RST, 8'h00, reset value of CTRL1
PULSE_WIDTH, 16, sys_clk cycles each pulse_out assertion lasts (1..65535)
LOCK_TIMEOUT, 24'd10000000, idle sys_clk cycles after which UNLOCKED reverts to LOCKED

Ports:
sys_clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
reg_addr  input  8  register address from I2C slave
wrdata  input  8  write data from I2C slave
wrdata_en  input  1  one-cycle write strobe, qualifies reg_addr/wrdata
rdata  output  8  read data, combinational from reg_addr and register state
ctrl0  output  8  CTRL0 contents
ctrl1  output  8  CTRL1 contents
pulse_out  output  8  self-clearing pulse outputs
status_in  input  8  asynchronous board status inputs
irq_n  output  1  registered interrupt, active low
unlocked  output  1  high while write-protect FSM is UNLOCKED

Behaviour:
- Reset values:
  - ctrl0=CTRL0_RST, ctrl1=CTRL1_RST.
  - pulse_out=0, irq_n=1, unlocked=0, scratch=0, sticky=0, mask=0.
  - Synchronizer flops reset to 0.
- rdata has zero latency: pure mux of reg_addr. The slave samples rdata the cycle after it updates reg_addr.
- All writes take effect on the sys_clk edge where wrdata_en=1.
- Register map (unmapped addresses read 8'h00, writes ignored):
  - 0x00 ID RO = BOARD_ID
  - 0x01 VER RO = FW_VER
  - 0x02 SCRATCH RW
  - 0x03 KEY WO: reads current lock state {7'b0,unlocked}
  - 0x04 CTRL0 RW, protected
  - 0x05 CTRL1 RW, protected
  - 0x06 PULSE WO, protected; reads 0x00
  - 0x08 STAT_LIVE RO = synchronized status
  - 0x09 STAT_STICKY RW1C
  - 0x0A IRQ_MASK RW: 1 = enabled
- Protected writes are silently dropped unless the lock FSM is UNLOCKED.
- Lock FSM, states LOCKED, KEY1, UNLOCKED:
  - LOCKED: write 0xA5 to 0x03 -> KEY1.
  - KEY1: next write anywhere is 0x5A to 0x03 -> UNLOCKED. Any other write -> LOCKED.
  - UNLOCKED: any write to 0x03 -> LOCKED.
  - Idle counter (24b) clears on every wrdata_en. Reaching LOCK_TIMEOUT in KEY1 or UNLOCKED -> LOCKED.
  - unlocked = (state==UNLOCKED), registered.
- Pulse:
  - Write D to 0x06 loads pulse_out<=D and a 16b down-counter <=PULSE_WIDTH.
  - At counter==1, pulse_out<=0 next edge, so each bit is high exactly PULSE_WIDTH cycles.
  - Rewrite mid-pulse replaces pulse_out and restarts the count. Writing 0x00 ends the pulse next edge.
- Status:
  - status_in passes through a 2-flop synchronizer; a third flop gives edge detect.
  - Sticky bit n sets on a rising edge of synced bit n; writing 1 to bit n of 0x09 clears it.
  - Simultaneous set and clear: set wins.
- irq_n <= ~|(sticky & mask), registered, so one cycle after the sticky/mask change.
- Reset asserted mid-pulse or while UNLOCKED returns everything to reset values immediately.

Optional Feature:
- Macro REG_BANK_ERR_CNT_EN.
- Defined:
  - Address 0x0B is an 8b error counter, incremented on each dropped protected write or write to an unmapped address.
  - Saturates at 0xFF.
  - Any write to 0x0B clears it; a clear coinciding with an error event yields 0x00.
  - Writes to 0x0B are never protected.
- Undefined: 0x0B is unmapped (reads 0x00), no counter logic.

Test Plan:
- Reset, read 0x00/0x01/0x04 -> 0x5A/0x10/CTRL0_RST; irq_n=1, unlocked=0.
- Locked, write 0x04=0x3C -> ctrl0 unchanged. Then write 0x03=0xA5, 0x03=0x5A, 0x04=0x3C -> ctrl0=0x3C, unlocked=1. Write 0x03=0x00 -> unlocked=0.
- Write 0x03=0xA5, 0x02=0x11, 0x03=0x5A -> stays LOCKED. Unlock, then idle LOCK_TIMEOUT cycles (set 100 in bench) -> unlocked falls.
- Unlocked, write 0x06=0x81 -> pulse_out=0x81 for exactly PULSE_WIDTH cycles, then 0x00. Rewrite 0x06=0x02 at cycle 5 -> 0x02 for a full PULSE_WIDTH from the rewrite.
- status_in[3] 0->1 -> 0x09 bit3 set within 3 cycles; mask 0x08 -> irq_n=0. Write 0x09=0x08 with a concurrent rising edge on bit3 -> bit stays set. Write 0x09=0x08 with no edge -> clears, irq_n=1 next cycle.
- With REG_BANK_ERR_CNT_EN: 300 locked writes to 0x04 -> 0x0B reads 0xFF. Write 0x0B -> 0x00. Without the macro: 0x0B reads 0x00.
